// File: rtl/stream_join.sv
// stream_join: joins two valid/ready streams (b, c) into one word {b, c}.
// Output is either a registered 2-entry buffer (COMBO=0) or a purely
// combinational pass-through (COMBO=1). join_cnt counts completed joins.
//
// Buffer FSM (COMBO=0):
//   state | meaning
//   EMPTY | no word buffered, d_valid low
//   ONE   | head holds one word, d_valid high
//   FULL  | head and tail both hold words, inputs stalled
module stream_join #(
    parameter int DATA_WD = 4,
    parameter int COMBO   = 0,
    parameter int CNT_WD  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 b_valid,
    input  logic [DATA_WD-1:0]   b_data,
    output logic                 b_ready,
    input  logic                 c_valid,
    input  logic [DATA_WD-1:0]   c_data,
    output logic                 c_ready,
    output logic                 d_valid,
    output logic [2*DATA_WD-1:0] d_data,
    input  logic                 d_ready,
    output logic [CNT_WD-1:0]    join_cnt
);

    logic                 space;
    logic                 join_fire;
    logic [2*DATA_WD-1:0] join_word;

    // Each ready depends only on the other side's valid, so neither source
    // can deadlock waiting on its own handshake.
    assign b_ready   = c_valid & space;
    assign c_ready   = b_valid & space;
    assign join_fire = b_valid & c_valid & space;
    assign join_word = {b_data, c_data};

    // Count completed joins; wraps naturally at 2^CNT_WD.
    always_ff @(posedge clk) begin
        if (rst)
            join_cnt <= '0;
        else if (join_fire)
            join_cnt <= join_cnt + CNT_WD'(1);
    end

    generate
        if (COMBO != 0) begin : g_combo
            assign space   = d_ready;
            assign d_valid = b_valid & c_valid;
            assign d_data  = join_word;
        end else begin : g_buf
            typedef enum logic [1:0] {
                EMPTY = 2'd0,
                ONE   = 2'd1,
                FULL  = 2'd2
            } state_t;

            state_t               state;
            logic                 valid_q;
            logic [2*DATA_WD-1:0] head;
            logic [2*DATA_WD-1:0] tail;
            logic                 pop;

            // Space comes from registered state only, keeping input readies
            // off the downstream d_ready path.
            assign space   = (state != FULL);
            assign pop     = valid_q & d_ready;
            assign d_valid = valid_q;
            assign d_data  = head;

            // Buffer FSM: tracks occupancy, head/tail storage and registered d_valid.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state   <= EMPTY;
                    valid_q <= 1'b0;
                    head    <= '0;
                    tail    <= '0;
                end else begin
                    case (state)
                        EMPTY: begin
                            if (join_fire) begin
                                head    <= join_word;
                                valid_q <= 1'b1;
                                state   <= ONE;
                            end
                        end
                        ONE: begin
                            if (join_fire && pop) begin
                                head <= join_word;
                            end else if (join_fire) begin
                                tail  <= join_word;
                                state <= FULL;
                            end else if (pop) begin
                                valid_q <= 1'b0;
                                state   <= EMPTY;
                            end
                        end
                        FULL: begin
                            if (pop) begin
                                head  <= tail;
                                state <= ONE;
                            end
                        end
                        default: begin
                            valid_q <= 1'b0;
                            state   <= EMPTY;
                        end
                    endcase
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_stream_join.sv
// Directed bench for stream_join (buffered build) plus a randomized
// scoreboard run on a second, combinational instance.
module tb_stream_join;

    localparam int DW = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          b_valid, c_valid, d_ready;
    logic [DW-1:0] b_data, c_data;
    logic          b_ready, c_ready, d_valid;
    logic [2*DW-1:0] d_data;
    logic [CW-1:0] join_cnt;

    logic          k_rst;
    logic          kb_v, kc_v, kd_r;
    logic [DW-1:0] kb_d, kc_d;
    logic          kb_r, kc_r, kd_v;
    logic [2*DW-1:0] kd_d;
    logic [CW-1:0] k_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stream_join #(.DATA_WD(DW), .COMBO(0), .CNT_WD(CW)) dut (
        .clk(clk), .rst(rst),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .c_valid(c_valid), .c_data(c_data), .c_ready(c_ready),
        .d_valid(d_valid), .d_data(d_data), .d_ready(d_ready),
        .join_cnt(join_cnt)
    );

    stream_join #(.DATA_WD(DW), .COMBO(1), .CNT_WD(CW)) dut_c (
        .clk(clk), .rst(k_rst),
        .b_valid(kb_v), .b_data(kb_d), .b_ready(kb_r),
        .c_valid(kc_v), .c_data(kc_d), .c_ready(kc_r),
        .d_valid(kd_v), .d_data(kd_d), .d_ready(kd_r),
        .join_cnt(k_cnt)
    );

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; b_valid = 1'b1; c_valid = 1'b1;
        b_data = 4'hF; c_data = 4'hF; d_ready = 1'b0;
        cyc(); cyc();
        #1;
        n_cmp++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL rst_d_valid: got %b want 0", d_valid); end
        n_cmp++; if (d_data !== 8'h00) begin n_err++; $display("FAIL rst_d_data: got %h want 00", d_data); end
        n_cmp++; if (join_cnt !== 16'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", join_cnt); end
        n_cmp++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL rst_b_ready: got %b want 1", b_ready); end
        rst = 1'b0; b_valid = 1'b1; c_valid = 1'b0;
        #1;
        n_cmp++; if (c_ready !== 1'b1 || b_ready !== 1'b0) begin n_err++; $display("FAIL post_rst_readies: got b=%b c=%b want b=0 c=1", b_ready, c_ready); end
        cyc();
        n_cmp++; if (join_cnt !== 16'd0 || d_valid !== 1'b0) begin n_err++; $display("FAIL rst_no_join: got cnt=%0d dv=%b want 0/0", join_cnt, d_valid); end
        b_valid = 1'b0;
    endtask

    task automatic test_basic();
        d_ready = 1'b1;
        b_valid = 1'b1; c_valid = 1'b1; b_data = 4'hA; c_data = 4'h5;
        #1;
        n_cmp++; if (b_ready !== 1'b1 || c_ready !== 1'b1) begin n_err++; $display("FAIL basic_readies: got b=%b c=%b want 1/1", b_ready, c_ready); end
        cyc();
        b_valid = 1'b0; c_valid = 1'b0;
        #1;
        n_cmp++; if (d_valid !== 1'b1) begin n_err++; $display("FAIL basic_d_valid: got %b want 1", d_valid); end
        n_cmp++; if (d_data !== 8'hA5) begin n_err++; $display("FAIL basic_d_data: got %h want a5", d_data); end
        n_cmp++; if (join_cnt !== 16'd1) begin n_err++; $display("FAIL basic_cnt: got %0d want 1", join_cnt); end
        cyc();
        n_cmp++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain: got %b want 0", d_valid); end
    endtask

    task automatic test_unbalanced();
        d_ready = 1'b1;
        b_valid = 1'b1; b_data = 4'h3; c_valid = 1'b0; c_data = 4'h0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (b_ready !== 1'b0 || c_ready !== 1'b1) begin n_err++; $display("FAIL unbal_wait%0d: got b=%b c=%b want b=0 c=1", i, b_ready, c_ready); end
            cyc();
        end
        n_cmp++; if (join_cnt !== 16'd1 || d_valid !== 1'b0) begin n_err++; $display("FAIL unbal_no_early_join: got cnt=%0d dv=%b want 1/0", join_cnt, d_valid); end
        c_valid = 1'b1; c_data = 4'hC;
        #1;
        n_cmp++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL unbal_b_ready: got %b want 1", b_ready); end
        cyc();
        b_valid = 1'b0; c_valid = 1'b0;
        #1;
        n_cmp++; if (d_valid !== 1'b1 || d_data !== 8'h3C) begin n_err++; $display("FAIL unbal_out: got dv=%b %h want 1 3c", d_valid, d_data); end
        n_cmp++; if (join_cnt !== 16'd2) begin n_err++; $display("FAIL unbal_cnt: got %0d want 2", join_cnt); end
        cyc();
        n_cmp++; if (d_valid !== 1'b0 || join_cnt !== 16'd2) begin n_err++; $display("FAIL unbal_single: got dv=%b cnt=%0d want 0/2", d_valid, join_cnt); end
    endtask

    task automatic test_backpressure();
        d_ready = 1'b0;
        b_valid = 1'b1; c_valid = 1'b1; b_data = 4'h1; c_data = 4'h1;
        cyc();
        b_data = 4'h2; c_data = 4'h2;
        #1;
        n_cmp++; if (d_valid !== 1'b1 || d_data !== 8'h11) begin n_err++; $display("FAIL bp_first: got dv=%b %h want 1 11", d_valid, d_data); end
        cyc();
        b_data = 4'h3; c_data = 4'h3;
        #1;
        n_cmp++; if (b_ready !== 1'b0 || c_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_readies: got b=%b c=%b want 0/0", b_ready, c_ready); end
        n_cmp++; if (d_data !== 8'h11) begin n_err++; $display("FAIL bp_hold: got %h want 11", d_data); end
        cyc();
        n_cmp++; if (b_ready !== 1'b0 || d_data !== 8'h11 || join_cnt !== 16'd4) begin n_err++; $display("FAIL bp_stall: got br=%b %h cnt=%0d want 0 11 4", b_ready, d_data, join_cnt); end
        d_ready = 1'b1;
        cyc();
        n_cmp++; if (d_data !== 8'h22 || b_ready !== 1'b1) begin n_err++; $display("FAIL bp_second: got %h br=%b want 22 1", d_data, b_ready); end
        cyc();
        b_valid = 1'b0; c_valid = 1'b0;
        #1;
        n_cmp++; if (d_valid !== 1'b1 || d_data !== 8'h33 || join_cnt !== 16'd5) begin n_err++; $display("FAIL bp_third: got dv=%b %h cnt=%0d want 1 33 5", d_valid, d_data, join_cnt); end
        cyc();
        n_cmp++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained: got %b want 0", d_valid); end
    endtask

    task automatic test_streaming();
        logic [7:0] w;
        rst = 1'b1; b_valid = 1'b0; c_valid = 1'b0;
        cyc();
        rst = 1'b0; d_ready = 1'b1;
        b_valid = 1'b1; c_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            w = 8'(i);
            b_data = w[7:4]; c_data = w[3:0];
            if (i > 0) begin
                #1;
                n_cmp++; if (d_valid !== 1'b1 || d_data !== 8'(i - 1)) begin n_err++; $display("FAIL stream_%0d: got dv=%b %h want 1 %h", i, d_valid, d_data, 8'(i - 1)); end
            end
            cyc();
        end
        b_valid = 1'b0; c_valid = 1'b0;
        #1;
        n_cmp++; if (d_valid !== 1'b1 || d_data !== 8'h63) begin n_err++; $display("FAIL stream_last: got dv=%b %h want 1 63", d_valid, d_data); end
        n_cmp++; if (join_cnt !== 16'd100) begin n_err++; $display("FAIL stream_cnt: got %0d want 100", join_cnt); end
        cyc();
        n_cmp++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain: got %b want 0", d_valid); end
    endtask

    task automatic test_reset_mid();
        d_ready = 1'b0;
        b_valid = 1'b1; c_valid = 1'b1; b_data = 4'h7; c_data = 4'h7;
        cyc();
        b_data = 4'h8; c_data = 4'h8;
        cyc();
        b_data = 4'h9; c_data = 4'h9;
        #1;
        n_cmp++; if (b_ready !== 1'b0 || d_data !== 8'h77) begin n_err++; $display("FAIL rmid_full: got br=%b %h want 0 77", b_ready, d_data); end
        rst = 1'b1;
        cyc();
        rst = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
        #1;
        n_cmp++; if (d_valid !== 1'b0 || d_data !== 8'h00) begin n_err++; $display("FAIL rmid_out: got dv=%b %h want 0 00", d_valid, d_data); end
        n_cmp++; if (join_cnt !== 16'd0) begin n_err++; $display("FAIL rmid_cnt: got %0d want 0", join_cnt); end
        d_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++; if (d_valid !== 1'b0 || join_cnt !== 16'd0) begin n_err++; $display("FAIL rmid_stale%0d: got dv=%b cnt=%0d want 0/0", i, d_valid, join_cnt); end
        end
    endtask

    task automatic test_combo();
        logic [DW-1:0] bq[$];
        logic [DW-1:0] cq[$];
        logic [2*DW-1:0] exp_w;
        logic [CW-1:0] exp_cnt;
        exp_cnt = '0;
        k_rst = 1'b1; kb_v = 1'b0; kc_v = 1'b0; kd_r = 1'b0; kb_d = '0; kc_d = '0;
        cyc();
        k_rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            kb_v = 1'($urandom_range(0, 1));
            kc_v = 1'($urandom_range(0, 1));
            kd_r = 1'($urandom_range(0, 1));
            kb_d = 4'($urandom);
            kc_d = 4'($urandom);
            #1;
            n_cmp++; if (kd_v !== (kb_v & kc_v)) begin n_err++; $display("FAIL combo_dv_%0d: got %b want %b", i, kd_v, kb_v & kc_v); end
            n_cmp++; if (kb_r !== (kc_v & kd_r) || kc_r !== (kb_v & kd_r)) begin n_err++; $display("FAIL combo_ready_%0d: got b=%b c=%b want b=%b c=%b", i, kb_r, kc_r, kc_v & kd_r, kb_v & kd_r); end
            n_cmp++; if (k_cnt !== exp_cnt) begin n_err++; $display("FAIL combo_cnt_%0d: got %0d want %0d", i, k_cnt, exp_cnt); end
            if (kb_v && kb_r) bq.push_back(kb_d);
            if (kc_v && kc_r) cq.push_back(kc_d);
            if (kd_v && kd_r) begin
                if (bq.size() == 0 || cq.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL combo_underflow_%0d: got output %h want no output", i, kd_d);
                end else begin
                    exp_w = {bq.pop_front(), cq.pop_front()};
                    n_cmp++; if (kd_d !== exp_w) begin n_err++; $display("FAIL combo_data_%0d: got %h want %h", i, kd_d, exp_w); end
                end
                exp_cnt = exp_cnt + CW'(1);
            end
            cyc();
        end
        n_cmp++; if (bq.size() != 0 || cq.size() != 0) begin n_err++; $display("FAIL combo_leftover: got b=%0d c=%0d want 0/0", bq.size(), cq.size()); end
        n_cmp++; if (k_cnt !== exp_cnt) begin n_err++; $display("FAIL combo_final_cnt: got %0d want %0d", k_cnt, exp_cnt); end
    endtask

    initial begin
        k_rst = 1'b1; kb_v = 1'b0; kc_v = 1'b0; kd_r = 1'b0; kb_d = '0; kc_d = '0;
        test_reset();
        test_basic();
        test_unbalanced();
        test_backpressure();
        test_streaming();
        test_reset_mid();
        test_combo();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stream_join.md
STREAM_JOIN -- requirements
Module: stream_join

Parameters
REQ-001 The block SHALL have parameter DATA_WD, default 4, giving the width of each input payload.
REQ-002 The block SHALL have parameter COMBO, default 0: 0 = registered 2-entry output buffer, 1 = purely combinational join.
REQ-003 The block SHALL have parameter CNT_WD, default 16, giving the width of the join counter.

Interface
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 b_valid  input  1  upper-half source valid.
REQ-007 b_data  input  DATA_WD  upper-half payload.
REQ-008 b_ready  output  1  upper-half accept.
REQ-009 c_valid  input  1  lower-half source valid.
REQ-010 c_data  input  DATA_WD  lower-half payload.
REQ-011 c_ready  output  1  lower-half accept.
REQ-012 d_valid  output  1  joined output valid.
REQ-013 d_data  output  2*DATA_WD  joined payload.
REQ-014 d_ready  input  1  downstream accept.
REQ-015 join_cnt  output  CNT_WD  number of completed input joins since reset.

Function
REQ-016 A join SHALL occur in a cycle only when b_valid, c_valid and the block's internal space condition are all high; b and c are never consumed individually.
REQ-017 In a join cycle, b_ready and c_ready SHALL both be high.
REQ-018 The output word SHALL be {b_data, c_data}: b in bits [2*DATA_WD-1:DATA_WD], c in [DATA_WD-1:0].
REQ-019 b_ready SHALL equal c_valid AND space; c_ready SHALL equal b_valid AND space. Neither ready may depend on its own valid.
REQ-020 COMBO=1: space = d_ready; d_valid = b_valid AND c_valid; d_data = {b_data, c_data}; zero latency; no data storage.
REQ-021 COMBO=0: the block SHALL contain a 2-entry FIFO with states EMPTY, ONE and FULL; space = (state != FULL), taken from registered state only.
REQ-022 COMBO=0: d_valid SHALL equal (state != EMPTY), and d_data SHALL equal the head entry; both are driven directly from registers.
REQ-023 COMBO=0: the latency from a join to d_valid SHALL be 1 cycle.
REQ-024 Transitions SHALL be as follows:
  - EMPTY + join -> ONE.
  - ONE + join with no pop -> FULL.
  - ONE + pop with no join -> EMPTY.
  - ONE + join and pop -> ONE, with the head replaced by the new word.
  - FULL + pop -> ONE, with the second entry promoted to head.
  - FULL never joins.
REQ-025 Sustained throughput SHALL be 1 word per cycle when all valids and d_ready are held high.
REQ-026 Output data SHALL be held stable while d_valid=1 and d_ready=0.
REQ-027 Order SHALL be strictly FIFO; no word is dropped or duplicated.
REQ-028 join_cnt SHALL increment by 1 on each join cycle and wrap from 2^CNT_WD-1 to 0.
REQ-029 d_valid SHALL never depend combinationally on d_ready.

Reset
REQ-030 While rst=1, on each clock edge: state <= EMPTY, join_cnt <= 0, and FIFO data registers <= 0.
REQ-031 During reset and in the first cycle after it, outputs SHALL be:
  - d_valid = 0, d_data = 0 (COMBO=0).
  - b_ready = c_valid and c_ready = b_valid, since space=1.
REQ-032 An rst asserted mid-transfer SHALL discard all buffered words; no partial word is emitted after reset.
REQ-033 Inputs presented in the cycle rst=1 SHALL NOT be joined and SHALL NOT be counted.

Verification (DATA_WD=4, COMBO=0 unless stated)
REQ-034 Basic join: b=0xA, c=0x5 both valid for one cycle, d_ready=1 -> next cycle d_valid=1, d_data=0xA5, join_cnt=1.
REQ-035 Unbalanced valids: b_valid=1 with b=0x3 held, c_valid=0 for 4 cycles, then c=0xC for 1 cycle -> b_ready=0 for the 4 cycles, one join only, d_data=0x3C.
REQ-036 Backpressure fill: d_ready=0, both inputs valid with words 0x11, 0x22, 0x33 -> state FULL after 2 joins, b_ready=c_ready=0, 0x33 held. With d_ready=1, outputs are 0x11, 0x22, 0x33 in order.
REQ-037 Streaming: all valids and d_ready=1 for 100 cycles with incrementing data -> 100 outputs, no gaps after the first, each output matches its input, join_cnt=100.
REQ-038 Reset mid-operation: FULL with d_ready=0, rst pulsed 1 cycle -> d_valid=0, join_cnt=0, and no stale words once d_ready=1.
REQ-039 COMBO=1 randomized run: random b_valid, c_valid and d_ready with scoreboard against the b/c queues -> zero mismatches, and d_valid==b_valid&c_valid in every cycle.
